// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parameterised synchronous FIFO with registered or FWFT read, level flags and sticky errors
module param_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0,
    parameter bit EVENT_MSGS = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             din,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             dout,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ovf_sticky,
    output logic                         udf_sticky,
    input  logic                         clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic             ovf_event;
    logic             udf_event;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    // Level flags depend on occupancy alone.
    always_comb begin
        full         = (count == CW'(DEPTH));
        empty        = (count == '0);
        almost_full  = (int'(count) >= AF_LEVEL);
        almost_empty = (int'(count) <= AE_LEVEL);
    end

    // Accept decisions; nothing is accepted while reset is asserted.
    always_comb begin
        wr_acc    = wr_en && !full && !rst;
        rd_acc    = rd_en && !empty && !rst;
        ovf_event = wr_en && full;
        udf_event = rd_en && empty;
    end

    // Storage array is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and sticky error flags; a new event beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_event) begin
                ovf_sticky <= 1'b1;
            end else if (clr_err) begin
                ovf_sticky <= 1'b0;
            end
            if (udf_event) begin
                udf_sticky <= 1'b1;
            end else if (clr_err) begin
                udf_sticky <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_registered
            // Registered read: dout loads the head on a pop and holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout     <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        dout <= mem[rd_ptr];
                    end
                end
            end
        end else begin : g_fwft
            // First-word-fall-through: head entry is always visible when not empty.
            always_comb begin
                dout     = mem[rd_ptr];
                rd_valid = !empty;
            end
        end
    endgenerate

    // Event reporting and internal consistency checks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (EVENT_MSGS && ovf_event) begin
                $error("[FIFO_OVERFLOW] param_fifo %m: write while full at %0t", $time);
            end
            if (EVENT_MSGS && udf_event) begin
                $warning("[FIFO_UNDERFLOW] param_fifo %m: read while empty at %0t", $time);
            end
            if (int'(count) > DEPTH) begin
                $error("[INVALID_STATE] param_fifo %m: count %0d exceeds depth at %0t", count, $time);
            end
            if ((int'(wr_ptr) >= DEPTH) || (int'(rd_ptr) >= DEPTH)) begin
                $error("[POINTER_MISMATCH] param_fifo %m: pointer out of range at %0t", $time);
            end
            if (rd_acc && $isunknown(mem[rd_ptr])) begin
                $error("[DATA_CORRUPTION] param_fifo %m: unknown data popped at %0t", $time);
            end
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - randomized model-checked bench for param_fifo
module tb_param_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en    [3];
    logic       rd_en    [3];
    logic       clr_err  [3];
    logic [7:0] din      [3];
    logic [7:0] dout     [3];
    logic       rd_valid [3];
    logic       full     [3];
    logic       empty    [3];
    logic       afull    [3];
    logic       aempty   [3];
    logic       ovf      [3];
    logic       udf      [3];
    logic [3:0] cnt_a;
    logic [2:0] cnt_b;
    logic [3:0] cnt_c;

    int vectors = 0;
    int errors  = 0;

    int dep     [3] = '{8, 5, 8};
    int is_fwft [3] = '{0, 0, 1};

    logic [7:0] mq [3][$];
    logic [7:0] exp_dout [3];
    logic       exp_ovf  [3];
    logic       exp_udf  [3];
    logic       m_racc;
    logic [7:0] m_popped;

    param_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(0), .EVENT_MSGS(1'b0)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .din(din[0]), .rd_en(rd_en[0]),
        .dout(dout[0]), .rd_valid(rd_valid[0]), .full(full[0]), .empty(empty[0]),
        .almost_full(afull[0]), .almost_empty(aempty[0]), .count(cnt_a),
        .ovf_sticky(ovf[0]), .udf_sticky(udf[0]), .clr_err(clr_err[0])
    );

    param_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0), .EVENT_MSGS(1'b0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .din(din[1]), .rd_en(rd_en[1]),
        .dout(dout[1]), .rd_valid(rd_valid[1]), .full(full[1]), .empty(empty[1]),
        .almost_full(afull[1]), .almost_empty(aempty[1]), .count(cnt_b),
        .ovf_sticky(ovf[1]), .udf_sticky(udf[1]), .clr_err(clr_err[1])
    );

    param_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(1), .EVENT_MSGS(1'b0)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en[2]), .din(din[2]), .rd_en(rd_en[2]),
        .dout(dout[2]), .rd_valid(rd_valid[2]), .full(full[2]), .empty(empty[2]),
        .almost_full(afull[2]), .almost_empty(aempty[2]), .count(cnt_c),
        .ovf_sticky(ovf[2]), .udf_sticky(udf[2]), .clr_err(clr_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int act_count(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            exp_dout[k] = 8'h00;
            exp_ovf[k]  = 1'b0;
            exp_udf[k]  = 1'b0;
        end
    endtask

    // One clock on instance i; the FIFO model is updated from the queue contents.
    task automatic cyc(input int i, input bit w, input bit r, input bit c, input logic [7:0] d);
        bit mfull;
        bit mempty;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            wr_en[k] = 1'b0; rd_en[k] = 1'b0; clr_err[k] = 1'b0; din[k] = 8'h00;
        end
        wr_en[i] = w; rd_en[i] = r; clr_err[i] = c; din[i] = d;
        mfull  = (mq[i].size() == dep[i]);
        mempty = (mq[i].size() == 0);
        @(posedge clk);
        #1;
        if (w && mfull) exp_ovf[i] = 1'b1;
        else if (c)     exp_ovf[i] = 1'b0;
        if (r && mempty) exp_udf[i] = 1'b1;
        else if (c)      exp_udf[i] = 1'b0;
        m_racc = r && !mempty;
        if (m_racc) begin
            m_popped = mq[i].pop_front();
            if (is_fwft[i] == 0) exp_dout[i] = m_popped;
        end
        if (w && !mfull) mq[i].push_back(d);
        wr_en[i] = 1'b0; rd_en[i] = 1'b0; clr_err[i] = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
        vectors++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty[0]); end
        vectors++; if (dout[0] !== 8'h00) begin errors++; $display("FAIL reset_dout got=%0h exp=0", dout[0]); end
        vectors++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid[0]); end
        vectors++; if ({ovf[0], udf[0]} !== 2'b00) begin errors++; $display("FAIL reset_sticky got=%0b exp=00", {ovf[0], udf[0]}); end
    endtask

    task automatic test_fill_drain();
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 1'b1, 1'b0, 1'b0, 8'(k));
            vectors++; if (cnt_a !== 4'(k)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", cnt_a, k); end
            vectors++; if (afull[0] !== (k >= 7)) begin errors++; $display("FAIL fill_almost_full got=%0b exp=%0b at %0d", afull[0], (k >= 7), k); end
            vectors++; if (full[0] !== (k == 8)) begin errors++; $display("FAIL fill_full got=%0b exp=%0b at %0d", full[0], (k == 8), k); end
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
            vectors++; if (dout[0] !== 8'(k)) begin errors++; $display("FAIL drain_dout got=%0h exp=%0h", dout[0], k); end
            vectors++; if (rd_valid[0] !== 1'b1) begin errors++; $display("FAIL drain_rd_valid got=%0b exp=1", rd_valid[0]); end
            cyc(0, 1'b0, 1'b0, 1'b0, 8'h00);
            vectors++; if (rd_valid[0] !== 1'b0) begin errors++; $display("FAIL drain_pulse got=%0b exp=0", rd_valid[0]); end
            vectors++; if (dout[0] !== 8'(k)) begin errors++; $display("FAIL drain_hold got=%0h exp=%0h", dout[0], k); end
        end
        vectors++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL drain_empty got=%0b exp=1", empty[0]); end
    endtask

    task automatic test_wrap();
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int k = 0; k < 4; k++) cyc(1, 1'b1, 1'b0, 1'b0, 8'($urandom));
            vectors++; if (cnt_b !== 3'd4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", cnt_b); end
            for (int k = 0; k < 4; k++) begin
                cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
                vectors++; if (dout[1] !== m_popped || rd_valid[1] !== 1'b1) begin
                    errors++; $display("FAIL wrap_dout got=%0h/%0b exp=%0h/1", dout[1], rd_valid[1], m_popped);
                end
            end
        end
        vectors++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%0b exp=1", empty[1]); end
    endtask

    task automatic test_full_both();
        for (int k = 0; k < 8; k++) cyc(0, 1'b1, 1'b0, 1'b0, 8'($urandom));
        cyc(0, 1'b1, 1'b1, 1'b0, 8'hEE);
        vectors++; if (cnt_a !== 4'd7) begin errors++; $display("FAIL fullboth_count got=%0d exp=7", cnt_a); end
        vectors++; if (dout[0] !== m_popped) begin errors++; $display("FAIL fullboth_head got=%0h exp=%0h", dout[0], m_popped); end
        vectors++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL fullboth_ovf got=%0b exp=1", ovf[0]); end
        for (int k = 0; k < 7; k++) begin
            cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
            vectors++; if (dout[0] !== m_popped) begin errors++; $display("FAIL fullboth_drain got=%0h exp=%0h", dout[0], m_popped); end
        end
        cyc(0, 1'b0, 1'b0, 1'b1, 8'h00);
        vectors++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL fullboth_clr got=%0b exp=0", ovf[0]); end
    endtask

    task automatic test_udf_clr();
        cyc(0, 1'b0, 1'b1, 1'b1, 8'h00);
        vectors++; if (udf[0] !== 1'b1) begin errors++; $display("FAIL udf_wins_clr got=%0b exp=1", udf[0]); end
        vectors++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL udf_count got=%0d exp=0", cnt_a); end
        cyc(0, 1'b0, 1'b0, 1'b1, 8'h00);
        vectors++; if (udf[0] !== 1'b0) begin errors++; $display("FAIL udf_clear got=%0b exp=0", udf[0]); end
        cyc(0, 1'b1, 1'b1, 1'b0, 8'h3C);
        vectors++; if (cnt_a !== 4'd1 || udf[0] !== 1'b1 || rd_valid[0] !== 1'b0) begin
            errors++; $display("FAIL emptyboth got=%0d/%0b/%0b exp=1/1/0", cnt_a, udf[0], rd_valid[0]);
        end
        cyc(0, 1'b0, 1'b1, 1'b1, 8'h00);
        vectors++; if (dout[0] !== 8'h3C || udf[0] !== 1'b0) begin
            errors++; $display("FAIL emptyboth_pop got=%0h/%0b exp=3c/0", dout[0], udf[0]);
        end
    endtask

    task automatic test_fwft();
        cyc(2, 1'b1, 1'b0, 1'b0, 8'hA5);
        vectors++; if (dout[2] !== 8'hA5 || rd_valid[2] !== 1'b1) begin
            errors++; $display("FAIL fwft_show got=%0h/%0b exp=a5/1", dout[2], rd_valid[2]);
        end
        cyc(2, 1'b0, 1'b0, 1'b0, 8'h00);
        vectors++; if (dout[2] !== 8'hA5 || rd_valid[2] !== 1'b1) begin
            errors++; $display("FAIL fwft_hold got=%0h/%0b exp=a5/1", dout[2], rd_valid[2]);
        end
        cyc(2, 1'b0, 1'b1, 1'b0, 8'h00);
        vectors++; if (empty[2] !== 1'b1 || rd_valid[2] !== 1'b0) begin
            errors++; $display("FAIL fwft_pop got=%0b/%0b exp=1/0", empty[2], rd_valid[2]);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) cyc(0, 1'b1, 1'b0, 1'b0, 8'($urandom));
        cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        vectors++; if (cnt_a !== 4'd0 || empty[0] !== 1'b1 || dout[0] !== 8'h00) begin
            errors++; $display("FAIL midreset got=%0d/%0b/%0h exp=0/1/0", cnt_a, empty[0], dout[0]);
        end
        #4 rst = 1'b0;
        cyc(0, 1'b1, 1'b0, 1'b0, 8'h5A);
        cyc(0, 1'b1, 1'b0, 1'b0, 8'hC3);
        vectors++; if (cnt_a !== 4'd2) begin errors++; $display("FAIL midreset_count got=%0d exp=2", cnt_a); end
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
            vectors++; if (dout[0] !== m_popped) begin errors++; $display("FAIL midreset_data got=%0h exp=%0h", dout[0], m_popped); end
        end
    endtask

    task automatic test_random();
        int  i;
        int  sz;
        bit  w;
        bit  r;
        bit  c;
        logic exp_rv;
        for (int n = 0; n < 600; n++) begin
            i = int'($urandom_range(0, 2));
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 8);
            cyc(i, w, r, c, 8'($urandom));
            sz = mq[i].size();
            exp_rv = (is_fwft[i] != 0) ? (sz != 0) : m_racc;
            vectors++; if (act_count(i) !== sz) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, act_count(i), sz); end
            vectors++; if (full[i] !== (sz == dep[i]) || empty[i] !== (sz == 0)) begin
                errors++; $display("FAIL rnd_full_empty[%0d] got=%0b%0b exp=%0b%0b", i, full[i], empty[i], (sz == dep[i]), (sz == 0));
            end
            vectors++; if (afull[i] !== (sz >= dep[i] - 1) || aempty[i] !== (sz <= 1)) begin
                errors++; $display("FAIL rnd_almost[%0d] got=%0b%0b exp=%0b%0b", i, afull[i], aempty[i], (sz >= dep[i] - 1), (sz <= 1));
            end
            vectors++; if (ovf[i] !== exp_ovf[i] || udf[i] !== exp_udf[i]) begin
                errors++; $display("FAIL rnd_sticky[%0d] got=%0b%0b exp=%0b%0b", i, ovf[i], udf[i], exp_ovf[i], exp_udf[i]);
            end
            vectors++; if (rd_valid[i] !== exp_rv) begin errors++; $display("FAIL rnd_rd_valid[%0d] got=%0b exp=%0b", i, rd_valid[i], exp_rv); end
            if (is_fwft[i] == 0) begin
                vectors++; if (dout[i] !== exp_dout[i]) begin errors++; $display("FAIL rnd_dout[%0d] got=%0h exp=%0h", i, dout[i], exp_dout[i]); end
            end else if (sz != 0) begin
                vectors++; if (dout[i] !== mq[i][0]) begin errors++; $display("FAIL rnd_head[%0d] got=%0h exp=%0h", i, dout[i], mq[i][0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_en[k] = 1'b0; rd_en[k] = 1'b0; clr_err[k] = 1'b0; din[k] = 8'h00;
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_both();
        test_udf_clr();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
